hazard_fwd_ctrl: RTL and testbench

// - Consumes the D-stage write-register address (rt/rd/31 selection) plus per-instruction

---
 rtl/hazard_pkg.sv | 57 +++++
 rtl/hazard_stage_reg.sv | 37 +++
 rtl/hazard_fwd_ctrl.sv | 82 ++++++++
 tb/tb_hazard_fwd_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings, stage record and small helpers for the hazard/forwarding controller.
package hazard_pkg;

    localparam int A_W = 5;
    localparam int T_W = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [A_W-1:0] a3;
        logic [T_W-1:0] tnew;
        logic [A_W-1:0] rs;
        logic [A_W-1:0] rt;
    } stage_t;

    localparam stage_t STAGE_ZERO = stage_t'({($bits(stage_t)){1'b0}});

    // Tnew counts down toward zero and holds there.
    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        if (t == {T_W{1'b0}}) begin
            return {T_W{1'b0}};
        end else begin
            return t - {{(T_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic fwd_hit(input stage_t s, input logic [A_W-1:0] idx);
        return (s.a3 != {A_W{1'b0}}) && (s.a3 == idx) && (s.tnew == {T_W{1'b0}});
    endfunction

    function automatic logic stall_hit(input stage_t s, input logic [A_W-1:0] idx,
                                       input logic [T_W-1:0] tuse);
        return (idx != {A_W{1'b0}}) && (tuse != TUSE_NONE) && (idx == s.a3) && (tuse < s.tnew);
    endfunction

    // Younger stages hold the newer value, so E beats M beats W.
    function automatic logic [1:0] fwd_d_sel(input logic [A_W-1:0] idx, input stage_t e,
                                             input stage_t m, input stage_t w);
        if (idx == {A_W{1'b0}}) begin
            return FWD_GRF;
        end else if (fwd_hit(e, idx)) begin
            return FWD_E;
        end else if (fwd_hit(m, idx)) begin
            return FWD_M;
        end else if (fwd_hit(w, idx)) begin
            return FWD_W;
        end else begin
            return FWD_GRF;
        end
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record with async clear, bubble insertion and optional tnew countdown.
module hazard_stage_reg
    import hazard_pkg::*;
#(
    parameter bit DEC = 1'b1
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   bubble,
    input  stage_t din,
    output stage_t dout
);

    stage_t next_s;

    // Next-state selection: bubble, pass-through, or pass-through with tnew countdown.
    always_comb begin
        next_s = din;
        if (bubble) begin
            next_s = STAGE_ZERO;
        end else if (DEC) begin
            next_s.tnew = tnew_dec(din.tnew);
        end else begin
            next_s = din;
        end
    end

    // Stage register with immediate clear on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= STAGE_ZERO;
        end else begin
            dout <= next_s;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for a five-stage pipeline: D-stage stall,
// D/E/M forwarding selects and the W-stage GRF write address.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int AW = A_W,
    parameter int TW = T_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    output logic          stall,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e,
    output logic          fwd_rt_m,
    output logic [AW-1:0] w_a3
);

    stage_t d_stage_s;
    stage_t e_r;
    stage_t m_r;
    stage_t w_r;
    logic   unused_bits_s;

    assign d_stage_s = '{a3: d_a3, tnew: d_tnew, rs: d_rs, rt: d_rt};

    hazard_stage_reg #(.DEC(1'b0)) u_stage_e (
        .clk(clk), .reset_n(reset_n), .bubble(stall), .din(d_stage_s), .dout(e_r)
    );

    hazard_stage_reg #(.DEC(1'b1)) u_stage_m (
        .clk(clk), .reset_n(reset_n), .bubble(1'b0), .din(e_r), .dout(m_r)
    );

    hazard_stage_reg #(.DEC(1'b1)) u_stage_w (
        .clk(clk), .reset_n(reset_n), .bubble(1'b0), .din(m_r), .dout(w_r)
    );

    // W can never stall: its tnew has always counted down to zero by then.
    always_comb begin
        stall = stall_hit(e_r, d_rs, d_tuse_rs) || stall_hit(m_r, d_rs, d_tuse_rs) ||
                stall_hit(e_r, d_rt, d_tuse_rt) || stall_hit(m_r, d_rt, d_tuse_rt);
    end

    // D operands keep their computed selects even while stalled.
    always_comb begin
        fwd_rs_d = fwd_d_sel(d_rs, e_r, m_r, w_r);
        fwd_rt_d = fwd_d_sel(d_rt, e_r, m_r, w_r);
    end

    // E operands may only take from M or W; M store data only from W.
    always_comb begin
        fwd_rs_e = FWD_GRF;
        fwd_rt_e = FWD_GRF;
        if (fwd_hit(m_r, e_r.rs)) begin
            fwd_rs_e = FWD_M;
        end else if (fwd_hit(w_r, e_r.rs)) begin
            fwd_rs_e = FWD_W;
        end else begin
            fwd_rs_e = FWD_GRF;
        end
        if (fwd_hit(m_r, e_r.rt)) begin
            fwd_rt_e = FWD_M;
        end else if (fwd_hit(w_r, e_r.rt)) begin
            fwd_rt_e = FWD_W;
        end else begin
            fwd_rt_e = FWD_GRF;
        end
        fwd_rt_m = fwd_hit(w_r, m_r.rt);
    end

    assign w_a3          = w_r.a3;
    assign unused_bits_s = ^{m_r.rs, w_r.rs, w_r.rt};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl with hand-computed expectations.
module tb_hazard_fwd_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_a3;
    logic [1:0] d_tnew;
    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic       fwd_rt_m;
    logic [4:0] w_a3;

    int n_tests;
    int n_fail;

    hazard_fwd_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_a3(d_a3), .d_tnew(d_tnew),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .w_a3(w_a3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [1:0] tuse_rs,
                         input logic [4:0] rt, input logic [1:0] tuse_rt,
                         input logic [4:0] a3, input logic [1:0] tnew);
        d_rs = rs; d_tuse_rs = tuse_rs;
        d_rt = rt; d_tuse_rt = tuse_rt;
        d_a3 = a3; d_tnew = tnew;
        #1;
    endtask

    task automatic nop();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        nop();
        check_val("reset_stall", {31'd0, stall}, 32'd0);
        check_val("reset_fwd_rs_d", {30'd0, fwd_rs_d}, 32'd0);
        check_val("reset_w_a3", {27'd0, w_a3}, 32'd0);
        #11;
        reset_n = 1'b1;
        step();

        // Load-use: lw $8 (tnew 2) followed by a consumer of $8 in E (tuse 1)
        drive(5'd1, 2'd3, 5'd2, 2'd3, 5'd8, 2'd2);
        check_val("lu_no_stall_empty", {31'd0, stall}, 32'd0);
        step();
        drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd11, 2'd1);
        check_val("lu_stall", {31'd0, stall}, 32'd1);
        step();
        check_val("lu_stall_released", {31'd0, stall}, 32'd0);
        check_val("lu_fwd_rs_d_none", {30'd0, fwd_rs_d}, 32'd0);
        step();
        nop();
        check_val("lu_fwd_rs_e_w", {30'd0, fwd_rs_e}, 32'd3);
        check_val("lu_w_a3", {27'd0, w_a3}, 32'd8);
        check_val("lu_no_second_stall", {31'd0, stall}, 32'd0);
        flush();

        // ALU result consumed by a branch in D
        drive(5'd1, 2'd3, 5'd2, 2'd3, 5'd9, 2'd1);
        step();
        drive(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
        check_val("alu_stall", {31'd0, stall}, 32'd1);
        step();
        check_val("alu_stall_released", {31'd0, stall}, 32'd0);
        check_val("alu_fwd_rs_d_m", {30'd0, fwd_rs_d}, 32'd2);
        step();
        flush();

        // Priority: three producers of $10 in E, M and W
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd0);
            step();
        end
        drive(5'd10, 2'd0, 5'd10, 2'd0, 5'd0, 2'd0);
        check_val("prio_fwd_rs_d_e", {30'd0, fwd_rs_d}, 32'd1);
        check_val("prio_fwd_rt_d_e", {30'd0, fwd_rt_d}, 32'd1);
        check_val("prio_stall", {31'd0, stall}, 32'd0);
        step();
        nop();
        check_val("prio_fwd_rs_e_m", {30'd0, fwd_rs_e}, 32'd2);
        check_val("prio_fwd_rt_e_m", {30'd0, fwd_rt_e}, 32'd2);
        step();
        drive(5'd10, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
        check_val("prio_fwd_rs_d_w", {30'd0, fwd_rs_d}, 32'd3);
        flush();

        // $0 never stalls or forwards
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);
        step();
        drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        check_val("zero_stall", {31'd0, stall}, 32'd0);
        check_val("zero_fwd_rs_d", {30'd0, fwd_rs_d}, 32'd0);
        flush();

        // Store data: producer $4 then sw with rt=4
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd0);
        step();
        drive(5'd3, 2'd1, 5'd4, 2'd2, 5'd0, 2'd0);
        check_val("sw_fwd_rt_d_e", {30'd0, fwd_rt_d}, 32'd1);
        check_val("sw_no_stall", {31'd0, stall}, 32'd0);
        step();
        nop();
        check_val("sw_fwd_rt_e_m", {30'd0, fwd_rt_e}, 32'd2);
        step();
        check_val("sw_fwd_rt_m_hit", {31'd0, fwd_rt_m}, 32'd1);
        flush();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd0);
        step();
        drive(5'd3, 2'd1, 5'd4, 2'd2, 5'd0, 2'd0);
        step();
        nop();
        step();
        check_val("sw_fwd_rt_m_miss", {31'd0, fwd_rt_m}, 32'd0);
        flush();

        // Asynchronous reset mid-stall with a3_E=5
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd2);
        step();
        drive(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
        check_val("rst_pre_stall", {31'd0, stall}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_stall_cleared", {31'd0, stall}, 32'd0);
        check_val("rst_w_a3", {27'd0, w_a3}, 32'd0);
        nop();
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("rst_w_a3_stays_zero", {27'd0, w_a3}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
